wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order writeback stream
//  (MEM/WB register outputs) and a multi-cycle mul/div unit (MDU) that completes out of band.
//  Pipeline writeback always wins.
//  MDU results queue in a small FIFO and drain into idle writeback slots.
//  A starvation counter requests a one-cycle pipeline bubble when the FIFO head waits too long.
//  Also exports a busy mask of registers with pending MDU results for the hazard unit.
// PARAMETERS
//  DEPTH       2   MDU result FIFO entries (power of two, 2..8)
//  STARVE_MAX  8   cycles the FIFO head may wait before hold_req is raised (1..255)
// PORTS
//  clock          in   1   system clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  pipe_we        in   1   reg_write from MEM/WB
//  pipe_waddr     in   5   destination register from MEM/WB
//  pipe_wdata     in   32  writeback data already selected by the WB mux
//  mdu_valid      in   1   MDU result available
//  mdu_waddr      in   5   MDU destination register
//  mdu_wdata      in   32  MDU result
//  mdu_ready      out  1   FIFO can accept: count < DEPTH (combinational from state)
//  rf_we          out  1   register-file write enable (registered)
//  rf_waddr       out  5   register-file write address (registered)
//  rf_wdata       out  32  register-file write data (registered)
//  hold_req       out  1   request upstream to insert one writeback bubble (registered)
//  busy_mask      out  32  bit r set while an MDU result for r is queued (registered)
// BEHAVIOUR
//  - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, hold_req=0, busy_mask=0.
//    FIFO empties; starve counter clears.
//  - Reset overrides all inputs in the same cycle; queued MDU results are discarded.
//  - "Pipe active" means pipe_we=1 and pipe_waddr!=0. Writes to r0 are dropped, never queued.
//  - MDU handshake: an entry is enqueued when mdu_valid && mdu_ready.
//    MDU writes with mdu_waddr=0 are accepted and discarded.
//  - Each cycle, exactly one source drives the next-edge rf_* outputs (1-cycle latency):
//    - Pipe active: rf_we=1 with the pipe addr/data.
//    - Else FIFO non-empty: rf_we=1 with the FIFO head; pop.
//    - Else, if the FIFO is empty and the enqueue is valid: the MDU result bypasses the FIFO
//      and is written directly (addr!=0).
//    - Else: rf_we=0; rf_waddr/rf_wdata hold their previous values.
//  - Simultaneous pop and push: allowed. Count is unchanged; order is preserved (FIFO).
//  - Full (count==DEPTH): mdu_ready=0. MDU must hold mdu_valid and its data stable.
//  - Starve counter:
//    - Clears when the FIFO is empty or on a pop.
//    - Otherwise increments each cycle the head is blocked by pipe activity; saturates
//      at STARVE_MAX.
//    - hold_req=1 in the cycle after the counter reaches STARVE_MAX.
//    - hold_req stays 1 until a pop occurs, then drops on the next edge.
//    - Upstream guarantees pipe_we=0 in the cycle following hold_req=1.
//  - busy_mask:
//    - A bit is set on enqueue of addr r (r!=0) and cleared when that entry pops or bypasses.
//    - Duplicate destinations are kept correct with per-register pending counts of
//      log2(DEPTH)+1 bits.
//    - Bit r reads 1 while its count is nonzero.
//  - WAW: a pipe write to r while busy_mask[r]=1 is a hazard-unit violation.
//    No arbitration fix is applied; the verif checker flags it.
// TESTING
//  1. Pipe-only traffic: pipe_we=1, addr 5, data 0xDEAD_BEEF
//     -> next edge rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; mdu_ready=1 throughout.
//  2. Bypass: pipe idle, FIFO empty, MDU (7, 0x1234) valid
//     -> next edge rf_we=1, rf_waddr=7; busy_mask stays 0.
//  3. Fill and drain:
//     - Pipe active 4 cycles while MDU offers (3,0xA) then (4,0xB)
//       -> mdu_ready=0 after 2 pushes; busy_mask=0x18.
//     - Pipe idle -> rf writes 3 then 4 on consecutive cycles; busy_mask returns to 0.
//  4. Starvation: STARVE_MAX=8, one queued entry, pipe active continuously
//     -> hold_req rises after 8 blocked cycles.
//     - Pipe idle one cycle -> entry written; hold_req falls next edge.
//  5. Reset mid-operation: FIFO holds 2 entries, hold_req=1, assert reset one cycle
//     -> all outputs 0, mdu_ready=1, no stale entry ever written afterwards.
//  6. r0 handling: pipe_we=1 with addr 0, and MDU with addr 0
//     -> rf_we never asserts for r0; FIFO count unchanged for the pipe write.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, MDU result handshake,
// arbitrated register-file write, stall request and pending-destination mask.
interface wb_port_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        hold_req;
  logic [31:0] busy_mask;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output mdu_valid, mdu_waddr, mdu_wdata,
    input  mdu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  hold_req, busy_mask
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  mdu_valid, mdu_waddr, mdu_wdata,
    output mdu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output hold_req, busy_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// queue in a small FIFO and drain into idle slots, with starvation-driven bubble requests.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input logic              clock,
  input logic              reset,
  wb_port_arbiter_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = 8;

  typedef logic [CW-1:0] cnt_t;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v >= SW'(STARVE_MAX)) return SW'(STARVE_MAX);
    return v + SW'(1);
  endfunction

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  cnt_t          count;
  cnt_t          count_nxt;
  cnt_t          pend_cnt [32];
  cnt_t          pend_nxt [32];
  logic [31:0]   busy_nxt;
  logic [SW-1:0] starve;
  logic [SW-1:0] starve_nxt;
  logic          hold_nxt;

  logic          vld_p1;
  logic [4:0]    waddr_p1;
  logic [31:0]   wdata_p1;
  logic          hold_p1;
  logic [31:0]   busy_p1;

  logic          pipe_act;
  logic          fifo_empty;
  logic          mdu_live;
  logic          pop;
  logic          bypass;
  logic          enq;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  assign wb.mdu_ready = (count < cnt_t'(DEPTH));
  assign head_addr    = fifo_addr[rd_ptr];
  assign head_data    = fifo_data[rd_ptr];

  // Slot decision: pipe first, then FIFO head, then direct MDU bypass.
  always_comb begin
    pipe_act   = wb.pipe_we && (wb.pipe_waddr != 5'd0);
    fifo_empty = (count == '0);
    mdu_live   = wb.mdu_valid && wb.mdu_ready && (wb.mdu_waddr != 5'd0);
    pop        = !pipe_act && !fifo_empty;
    bypass     = !pipe_act && fifo_empty && mdu_live;
    enq        = mdu_live && !bypass;
    count_nxt  = count + cnt_t'(enq) - cnt_t'(pop);
  end

  // Per-register pending counts keep duplicate destinations correct.
  always_comb begin
    busy_nxt = '0;
    for (int r = 0; r < 32; r++) begin
      pend_nxt[r] = pend_cnt[r];
      if (enq && (wb.mdu_waddr == 5'(r))) pend_nxt[r] = pend_nxt[r] + cnt_t'(1);
      if (pop && (head_addr == 5'(r)))    pend_nxt[r] = pend_nxt[r] - cnt_t'(1);
      busy_nxt[r] = (pend_nxt[r] != '0);
    end
  end

  always_comb begin
    if (fifo_empty || pop) starve_nxt = '0;
    else                   starve_nxt = sat_inc(starve);
    hold_nxt = pop ? 1'b0 : (hold_p1 || (starve_nxt == SW'(STARVE_MAX)));
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= wb.mdu_waddr;
      fifo_data[wr_ptr] <= wb.mdu_wdata;
    end
  end

  // p1: registered write port, stall request and busy mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      starve   <= '0;
      hold_p1  <= 1'b0;
      busy_p1  <= '0;
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      for (int r = 0; r < 32; r++) pend_cnt[r] <= '0;
    end else begin
      count   <= count_nxt;
      starve  <= starve_nxt;
      hold_p1 <= hold_nxt;
      busy_p1 <= busy_nxt;
      for (int r = 0; r < 32; r++) pend_cnt[r] <= pend_nxt[r];
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (pipe_act) begin
        vld_p1   <= 1'b1;
        waddr_p1 <= wb.pipe_waddr;
        wdata_p1 <= wb.pipe_wdata;
      end else if (pop) begin
        vld_p1   <= 1'b1;
        waddr_p1 <= head_addr;
        wdata_p1 <= head_data;
      end else if (bypass) begin
        vld_p1   <= 1'b1;
        waddr_p1 <= wb.mdu_waddr;
        wdata_p1 <= wb.mdu_wdata;
      end else begin
        vld_p1   <= 1'b0;
      end
    end
  end

  assign wb.rf_we     = vld_p1;
  assign wb.rf_waddr  = waddr_p1;
  assign wb.rf_wdata  = wdata_p1;
  assign wb.hold_req  = hold_p1;
  assign wb.busy_mask = busy_p1;

endmodule
